pbus_space_arbiter: RTL
=======================

// Module: pbus_space_arbiter
// PURPOSE
// Shares the synchronous (Addr,Data) address space behind the PBus interface
// between the host (RD/WR strobes from the PBus interface) and NREQ on-chip
// requesters. Host cycles have absolute priority and are never stalled: the
// interface runs fixed-timing handshakes. Requesters get round-robin bursts.
// PARAMETERS
// NREQ       4   number of internal requesters (2..8)
// AW         8   address width
// DW        32   data width
// BURST_MAX  4   max beats per grant before rotation (1..15)
// PORTS
// Clk         in   1        system clock
// PBusResetN  in   1        reset, asynchronous, active-low
// HostRD      in   1        host read strobe (interface RD)
// HostWR      in   1        host write strobe (interface WR)
// HostAddr    in   AW       host address
// HostWData   in   DW       host write data
// Req         in   NREQ     per-requester access request, level
// ReqWr       in   NREQ     1=write, 0=read; sampled per beat
// ReqAddr     in   NREQ*AW  packed; requester i at [i*AW +: AW]
// ReqWData    in   NREQ*DW  packed; requester i at [i*DW +: DW]
// Gnt         out  NREQ     one-hot grant, registered
// Ack         out  NREQ     beat performed this cycle (comb.)
// BusRD       out  1        read strobe to address space
// BusWR       out  1        write strobe to address space
// BusAddr     out  AW       address to address space
// BusWData    out  DW       write data to address space
// BusHost     out  1        1 = current bus cycle is a host cycle
// BEHAVIOUR
// - HostAct = HostRD|HostWR. HostRD&HostWR together: read wins, no write.
// - Bus mux combinational, zero latency: HostAct -> BusRD/BusWR/BusAddr/BusWData
//   from host, BusHost=1. Else if Gnt[g]&Req[g]: beat for g, Ack[g]=1,
//   BusWR=ReqWr[g], BusRD=!ReqWr[g]. Else BusRD=BusWR=0, BusAddr/BusWData=0.
// - Host cycle steals the beat: Ack=0, beat count unchanged, Gnt held.
// - States IDLE, GRANT. Regs: Gnt, Last (last owner idx), BeatCnt (4 bits).
// - IDLE: Gnt=0. Any Req -> GRANT next edge; winner = first Req set scanning
//   Last+1, Last+2 ... mod NREQ; BeatCnt=0.
// - GRANT, owner g: beat performed -> BeatCnt+1. Release when Req[g]=0, or a
//   beat completes with BeatCnt==BURST_MAX-1. On release Last=g; if any Req
//   (others, then g last in scan) -> new grant next edge, no idle bubble;
//   else IDLE. Release decision uses Req sampled at that edge.
// - Latency: Req rises in IDLE at edge n -> Gnt at edge n+1; first Ack in
//   the same cycle if no host cycle.
// - Req[g] dropped mid-burst: no Ack that cycle, Gnt clears next edge.
// - BURST_MAX=1: rotation after every beat.
// - Reset (async, any state): Gnt=0, IDLE, BeatCnt=0, Last=NREQ-1 (req 0
//   first). All bus outputs 0 and Ack=0 while reset asserted.
// - Gnt always one-hot or zero; never changes on a host-stolen cycle.
// TESTING
// - Reset mid-burst: Gnt 0010 -> assert PBusResetN=0 between edges ->
//   Gnt=0000, BusRD=BusWR=0 immediately; release -> Req=0001 gets first.
// - Req=1111 held, BURST_MAX=4: grants 0,1,2,3,0 each 4 Acks, no gaps.
// - Req[1] only, 10 beats: Gnt[1] continuous, Acks 4,4,2, re-grant no bubble.
// - Owner 2, HostWR pulse at beat 2 (HostAddr=8'h10): BusHost=1, BusWR=1,
//   BusAddr=8'h10, Ack=0, burst still 4 beats total.
// - Host 4-cycle read (HostRD 2 cycles) with Req=0001 idle: Gnt rises,
//   no Ack while HostRD=1, first Ack next cycle.
// - Req[3] drops after 1 beat with Req[0] pending: Gnt 1000 -> 0001, Last=3.

Source files
------------

// File: rtl/pbus_space_arbiter.sv
// Arbitrates the PBus-side address space between the host strobes and NREQ
// on-chip requesters; host cycles always win, requesters share round-robin bursts.
module pbus_space_arbiter #(
  parameter int NREQ      = 4,
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic               Clk,
  input  logic               PBusResetN,
  input  logic               HostRD,
  input  logic               HostWR,
  input  logic [AW-1:0]      HostAddr,
  input  logic [DW-1:0]      HostWData,
  input  logic [NREQ-1:0]    Req,
  input  logic [NREQ-1:0]    ReqWr,
  input  logic [NREQ*AW-1:0] ReqAddr,
  input  logic [NREQ*DW-1:0] ReqWData,
  output logic [NREQ-1:0]    Gnt,
  output logic [NREQ-1:0]    Ack,
  output logic               BusRD,
  output logic               BusWR,
  output logic [AW-1:0]      BusAddr,
  output logic [DW-1:0]      BusWData,
  output logic               BusHost
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [3:0]    BEAT_LAST = 4'(BURST_MAX - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);

  logic [0:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [3:0]      beat_q, beat_d;

  logic [IW-1:0]   owner;
  logic            owner_req;
  logic            host_act;
  logic            beat;
  logic            burst_done;

  // Round-robin: first set request scanning last+1, last+2, ... wrapping,
  // so the previous owner itself is considered last.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IW-1:0]   last);
    logic [NREQ-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
    logic [IW-1:0] i;
    i = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (oh[k]) i = IW'(k);
    end
    return i;
  endfunction

  assign owner      = onehot_idx(gnt_q);
  assign owner_req  = |(gnt_q & Req);
  assign host_act   = HostRD | HostWR;
  assign beat       = (state_q == S_GRANT) && owner_req && !host_act;
  assign burst_done = beat && (beat_q == BEAT_LAST);

  // Zero-latency bus mux; everything is forced quiet while reset is held.
  always_comb begin
    BusRD    = 1'b0;
    BusWR    = 1'b0;
    BusAddr  = '0;
    BusWData = '0;
    BusHost  = 1'b0;
    Ack      = '0;
    if (PBusResetN) begin
      if (host_act) begin
        BusRD    = HostRD;
        BusWR    = HostWR & ~HostRD;
        BusAddr  = HostAddr;
        BusWData = HostWData;
        BusHost  = 1'b1;
      end else if (beat) begin
        BusWR    = ReqWr[owner];
        BusRD    = ~ReqWr[owner];
        BusAddr  = ReqAddr[owner*AW +: AW];
        BusWData = ReqWData[owner*DW +: DW];
        Ack      = gnt_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (|Req) begin
          state_d = S_GRANT;
          gnt_d   = rr_pick(Req, last_q);
          beat_d  = '0;
        end
      end
      S_GRANT: begin
        // A released grant hands over directly to the next requester, if any.
        if (!owner_req || burst_done) begin
          last_d  = owner;
          gnt_d   = rr_pick(Req, owner);
          beat_d  = '0;
          state_d = (|Req) ? S_GRANT : S_IDLE;
        end else if (beat) begin
          beat_d = beat_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge PBusResetN) begin
    if (!PBusResetN) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign Gnt = gnt_q;

endmodule
